// File: rtl/popcount_window_acc.sv
// Sums per-cycle adder-tree popcounts over a programmable-length window.
// The binary window sum is presented with a valid/ready handshake.
module popcount_window_acc #(
    parameter int IWID = 5,
    parameter int IMAX = 9,
    parameter int BLEN = 256,
    parameter int LWID = $clog2(BLEN + 1),
    parameter int OWID = IWID + $clog2(BLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iStart,
    input  logic [LWID-1:0] iLen,
    input  logic            iValid,
    input  logic [IWID-1:0] iData,
    input  logic            iReady,
    output logic            oValid,
    output logic [OWID-1:0] oData,
    output logic            oBusy,
    output logic            oErr
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    localparam logic [IWID-1:0] IMAX_V = IWID'(IMAX);
    localparam logic [LWID-1:0] BLEN_V = LWID'(BLEN);

    state_t          state_q, state_d;
    logic [LWID-1:0] len_q, len_d;
    logic [LWID-1:0] cnt_q, cnt_d;
    logic [OWID-1:0] acc_q, acc_d;
    logic [OWID-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic            over;
    logic [IWID-1:0] sample;
    logic [OWID-1:0] sum;
    logic [LWID-1:0] start_len;
    logic            handshake;
    logic            start_ok;

    always_comb begin
        over      = (iData > IMAX_V);
        sample    = over ? IMAX_V : iData;
        sum       = acc_q + OWID'(sample);
        start_len = ((iLen == '0) || (iLen > BLEN_V)) ? BLEN_V : iLen;
        handshake = (state_q == HOLD) && valid_q && iReady;
        start_ok  = iStart && ((state_q == IDLE) || handshake);
    end

    // A start accepted at the HOLD handshake reuses the IDLE initialisation.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;

        case (state_q)
            IDLE: ;
            ACC: begin
                if (iValid) begin
                    acc_d = sum;
                    cnt_d = cnt_q + LWID'(1);
                    if (over) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == len_q - LWID'(1)) begin
                        data_d  = sum;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_ok) begin
            len_d   = start_len;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign oValid = valid_q;
    assign oData  = data_q;
    assign oBusy  = (state_q != IDLE);
    assign oErr   = err_q;

endmodule

// File: tb/tb_popcount_window_acc.sv
// Directed testbench for popcount_window_acc with hand-computed window sums.
module tb_popcount_window_acc;

    localparam int IWID = 5;
    localparam int LWID = 9;
    localparam int OWID = 13;

    logic            clk;
    logic            rst_n;
    logic            iStart;
    logic [LWID-1:0] iLen;
    logic            iValid;
    logic [IWID-1:0] iData;
    logic            iReady;
    logic            oValid;
    logic [OWID-1:0] oData;
    logic            oBusy;
    logic            oErr;

    int checkCount = 0;
    int errorCount = 0;

    popcount_window_acc dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iStart (iStart),
        .iLen   (iLen),
        .iValid (iValid),
        .iData  (iData),
        .iReady (iReady),
        .oValid (oValid),
        .oData  (oData),
        .oBusy  (oBusy),
        .oErr   (oErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the clock edge.
    task automatic applyStimulus(input logic start, input int len, input logic valid,
                                 input int data);
        iStart = start;
        iLen   = LWID'(len);
        iValid = valid;
        iData  = IWID'(data);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 0, 1'b0, 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        iStart = 1'b0;
        iLen   = '0;
        iValid = 1'b0;
        iData  = '0;
        iReady = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        checkOutput("reset oValid", int'(oValid), 0);
        checkOutput("reset oData", int'(oData), 0);
        checkOutput("reset oBusy", int'(oBusy), 0);
        checkOutput("reset oErr", int'(oErr), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic window: 4 x 9
        applyStimulus(1'b1, 4, 1'b0, 0);
        checkOutput("basic busy after start", int'(oBusy), 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("basic no early valid", int'(oValid), 0);
            applyStimulus(1'b0, 0, 1'b1, 9);
        end
        checkOutput("basic oValid", int'(oValid), 1);
        checkOutput("basic oData", int'(oData), 36);
        checkOutput("basic oErr", int'(oErr), 0);
        idleCycle();
        checkOutput("basic valid one cycle", int'(oValid), 0);
        checkOutput("basic busy drops", int'(oBusy), 0);

        // Gapped input: 2,_,5,_,_,7
        applyStimulus(1'b1, 3, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 2);
        applyStimulus(1'b0, 0, 1'b0, 9);
        applyStimulus(1'b0, 0, 1'b1, 5);
        applyStimulus(1'b0, 0, 1'b0, 9);
        applyStimulus(1'b0, 0, 1'b0, 9);
        checkOutput("gap no early valid", int'(oValid), 0);
        applyStimulus(1'b0, 0, 1'b1, 7);
        checkOutput("gap oValid", int'(oValid), 1);
        checkOutput("gap oData", int'(oData), 14);
        idleCycle();

        // Backpressure: 3+4 held for 5 cycles while extra samples arrive
        iReady = 1'b0;
        applyStimulus(1'b1, 2, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 3);
        applyStimulus(1'b0, 0, 1'b1, 4);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp hold oValid", int'(oValid), 1);
            checkOutput("bp hold oData", int'(oData), 7);
            applyStimulus(1'b0, 0, 1'b1, 9);
        end
        iReady = 1'b1;
        applyStimulus(1'b0, 0, 1'b1, 9);
        checkOutput("bp released", int'(oValid), 0);
        applyStimulus(1'b1, 1, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 1);
        checkOutput("bp next window oData", int'(oData), 1);

        // Back-to-back: start accepted on the handshake cycle
        applyStimulus(1'b1, 2, 1'b0, 0);
        checkOutput("b2b valid dropped", int'(oValid), 0);
        checkOutput("b2b busy stays", int'(oBusy), 1);
        applyStimulus(1'b0, 0, 1'b1, 1);
        applyStimulus(1'b0, 0, 1'b1, 2);
        checkOutput("b2b oData", int'(oData), 3);
        idleCycle();

        // Start and valid together in IDLE: that sample is not counted
        applyStimulus(1'b1, 1, 1'b1, 9);
        applyStimulus(1'b0, 0, 1'b1, 2);
        checkOutput("start+valid oData", int'(oData), 2);
        idleCycle();

        // Full length via iLen=0 and iLen=300
        for (int pass = 0; pass < 2; pass++) begin
            applyStimulus(1'b1, (pass == 0) ? 0 : 300, 1'b0, 0);
            for (int i = 0; i < 255; i++) begin
                applyStimulus(1'b0, 0, 1'b1, 9);
            end
            checkOutput("full no valid at 255", int'(oValid), 0);
            applyStimulus(1'b0, 0, 1'b1, 9);
            checkOutput("full oValid", int'(oValid), 1);
            checkOutput("full oData", int'(oData), 2304);
            idleCycle();
        end

        // Clamp: 15 -> 9, plus 3
        iReady = 1'b0;
        applyStimulus(1'b1, 2, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 15);
        checkOutput("clamp err set", int'(oErr), 1);
        applyStimulus(1'b0, 0, 1'b1, 3);
        checkOutput("clamp oData", int'(oData), 12);
        idleCycle();
        checkOutput("clamp err in hold", int'(oErr), 1);
        iReady = 1'b1;
        idleCycle();
        checkOutput("clamp err after handshake", int'(oErr), 1);
        applyStimulus(1'b1, 2, 1'b0, 0);
        checkOutput("clamp err cleared", int'(oErr), 0);
        idleCycle();
        idleCycle();
        idleCycle();

        // Reset mid-window
        applyStimulus(1'b1, 4, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 15);
        iData = IWID'(1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst oValid", int'(oValid), 0);
        checkOutput("rst oData", int'(oData), 0);
        checkOutput("rst oBusy", int'(oBusy), 0);
        checkOutput("rst oErr", int'(oErr), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 2, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 1);
        applyStimulus(1'b0, 0, 1'b1, 1);
        checkOutput("post-rst oValid", int'(oValid), 1);
        checkOutput("post-rst oData", int'(oData), 2);
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
